// File: rtl/speicher_pkg.sv
// Shared types and constants for the memory controller: FSM states, request
// sources and the address bit that selects memory-mapped I/O.
package speicher_pkg;

    localparam int unsigned ADR_BITS = 32;
    localparam int unsigned IO_BIT   = 31;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RAM_START  = 2'd1,
        RAM_WARTEN = 2'd2,
        FERTIG     = 2'd3
    } zustand_t;

    typedef enum logic {
        QUELLE_BEFEHL = 1'b0,
        QUELLE_DATEN  = 1'b1
    } quelle_t;

    function automatic logic ist_io(input logic [ADR_BITS-1:0] adresse);
        return adresse[IO_BIT];
    endfunction

endpackage

// File: rtl/speicher_steuerung_led_register.sv
// Memory-mapped LED register: write enable, asynchronous reset, registered read-back.
module led_register #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_c,
    input  logic [BITS-1:0] wert_c,
    output logic [BITS-1:0] leds
);

    logic [BITS-1:0] leds_q;
    logic [BITS-1:0] leds_d;

    always_comb begin
        leds_d = leds_q;
        if (we_c) begin
            leds_d = wert_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: rtl/speicher_steuerung.sv
// Memory controller: arbitrates fetch and load/store requests onto a single-ported
// word RAM and decodes address bit 31 as access to the on-chip LED register.
module speicher_steuerung
    import speicher_pkg::*;
#(
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned WORDS    = 32,
    parameter int unsigned LEDBITS  = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       BefehlAnfrage,
    input  logic [ADR_BITS-1:0]        BefehlAdresse,
    output logic [WORDSIZE-1:0]        Befehl,
    output logic                       BefehlBereit,
    input  logic                       DatenLesen,
    input  logic                       DatenSchreiben,
    input  logic [ADR_BITS-1:0]        DatenAdresse,
    input  logic [WORDSIZE-1:0]        DatenSchreibwert,
    output logic [WORDSIZE-1:0]        DatenLesewert,
    output logic                       DatenFertig,
    output logic                       RamLesenAn,
    output logic                       RamSchreibenAn,
    output logic [$clog2(WORDS)-1:0]   RamAdresse,
    output logic [WORDSIZE-1:0]        RamDatenRein,
    input  logic [WORDSIZE-1:0]        RamDatenRaus,
    input  logic                       RamDatenBereit,
    input  logic                       RamDatenGeschrieben,
    output logic [LEDBITS-1:0]         LEDs
);

    localparam int unsigned AW = $clog2(WORDS);

    zustand_t              zustand_q,       zustand_d;
    quelle_t               quelle_q,        quelle_d;
    logic                  schreiben_q,     schreiben_d;
    logic [WORDSIZE-1:0]   befehl_q,        befehl_d;
    logic                  befehl_bereit_q, befehl_bereit_d;
    logic [WORDSIZE-1:0]   daten_lese_q,    daten_lese_d;
    logic                  daten_fertig_q,  daten_fertig_d;
    logic                  ram_lesen_q,     ram_lesen_d;
    logic                  ram_schreib_q,   ram_schreib_d;
    logic [AW-1:0]         ram_adresse_q,   ram_adresse_d;
    logic [WORDSIZE-1:0]   ram_rein_q,      ram_rein_d;

    logic                  led_we_c;
    logic [LEDBITS-1:0]    led_wert_c;
    logic [LEDBITS-1:0]    led_lesen;
    logic                  daten_anfrage_c;

    // Address bits above the RAM index are don't-care: RAM addresses wrap.
    logic                  adr_unused_c;
    assign adr_unused_c = ^{BefehlAdresse[ADR_BITS-1:AW], DatenAdresse[IO_BIT-1:AW]};

    assign daten_anfrage_c = DatenLesen | DatenSchreiben;
    assign led_wert_c      = DatenSchreibwert[LEDBITS-1:0];

    led_register #(
        .BITS (LEDBITS)
    ) u_led_register (
        .clk    (Clock),
        .rst    (Reset),
        .we_c   (led_we_c),
        .wert_c (led_wert_c),
        .leds   (led_lesen)
    );

    // Next-state and output logic; strobes and pulses default low every cycle.
    always_comb begin
        zustand_d       = zustand_q;
        quelle_d        = quelle_q;
        schreiben_d     = schreiben_q;
        befehl_d        = befehl_q;
        befehl_bereit_d = 1'b0;
        daten_lese_d    = daten_lese_q;
        daten_fertig_d  = 1'b0;
        ram_lesen_d     = 1'b0;
        ram_schreib_d   = 1'b0;
        ram_adresse_d   = ram_adresse_q;
        ram_rein_d      = ram_rein_q;
        led_we_c        = 1'b0;

        unique case (zustand_q)
            IDLE: begin
                if (daten_anfrage_c) begin
                    quelle_d    = QUELLE_DATEN;
                    schreiben_d = DatenSchreiben;
                    if (ist_io(DatenAdresse)) begin
                        zustand_d      = FERTIG;
                        daten_fertig_d = 1'b1;
                        if (DatenSchreiben) begin
                            led_we_c = 1'b1;
                        end else begin
                            daten_lese_d = WORDSIZE'(led_lesen);
                        end
                    end else begin
                        zustand_d     = RAM_START;
                        ram_adresse_d = DatenAdresse[AW-1:0];
                        if (DatenSchreiben) begin
                            ram_schreib_d = 1'b1;
                            ram_rein_d    = DatenSchreibwert;
                        end else begin
                            ram_lesen_d = 1'b1;
                        end
                    end
                end else if (BefehlAnfrage) begin
                    // Fetches never decode I/O; bit 31 is dropped with the other high bits.
                    quelle_d      = QUELLE_BEFEHL;
                    schreiben_d   = 1'b0;
                    zustand_d     = RAM_START;
                    ram_adresse_d = BefehlAdresse[AW-1:0];
                    ram_lesen_d   = 1'b1;
                end
            end

            RAM_START: begin
                zustand_d = RAM_WARTEN;
            end

            RAM_WARTEN: begin
                if (schreiben_q) begin
                    if (RamDatenGeschrieben) begin
                        zustand_d      = FERTIG;
                        daten_fertig_d = 1'b1;
                    end
                end else if (RamDatenBereit) begin
                    zustand_d = FERTIG;
                    if (quelle_q == QUELLE_BEFEHL) begin
                        befehl_d        = RamDatenRaus;
                        befehl_bereit_d = 1'b1;
                    end else begin
                        daten_lese_d   = RamDatenRaus;
                        daten_fertig_d = 1'b1;
                    end
                end
            end

            FERTIG: begin
                zustand_d = IDLE;
            end

            default: begin
                zustand_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand_q       <= IDLE;
            quelle_q        <= QUELLE_BEFEHL;
            schreiben_q     <= 1'b0;
            befehl_q        <= '0;
            befehl_bereit_q <= 1'b0;
            daten_lese_q    <= '0;
            daten_fertig_q  <= 1'b0;
            ram_lesen_q     <= 1'b0;
            ram_schreib_q   <= 1'b0;
            ram_adresse_q   <= '0;
            ram_rein_q      <= '0;
        end else begin
            zustand_q       <= zustand_d;
            quelle_q        <= quelle_d;
            schreiben_q     <= schreiben_d;
            befehl_q        <= befehl_d;
            befehl_bereit_q <= befehl_bereit_d;
            daten_lese_q    <= daten_lese_d;
            daten_fertig_q  <= daten_fertig_d;
            ram_lesen_q     <= ram_lesen_d;
            ram_schreib_q   <= ram_schreib_d;
            ram_adresse_q   <= ram_adresse_d;
            ram_rein_q      <= ram_rein_d;
        end
    end

    assign Befehl         = befehl_q;
    assign BefehlBereit   = befehl_bereit_q;
    assign DatenLesewert  = daten_lese_q;
    assign DatenFertig    = daten_fertig_q;
    assign RamLesenAn     = ram_lesen_q;
    assign RamSchreibenAn = ram_schreib_q;
    assign RamAdresse     = ram_adresse_q;
    assign RamDatenRein   = ram_rein_q;
    assign LEDs           = led_lesen;

endmodule

// File: doc/speicher_steuerung.md
# speicher_steuerung

Memory controller between the processor core and the word-addressed `RAM` block. It arbitrates instruction-fetch and data load/store requests onto the single-ported RAM handshake (`LesenAn`/`DatenBereit`, `SchreibenAn`/`DatenGeschrieben`). It also decodes memory-mapped I/O: address bit 31 selects an on-chip LED register instead of RAM.

## Interface
- `WORDSIZE`, 32: data word width.
- `WORDS`, 32: RAM depth in words; RAM address width is `$clog2(WORDS)`.
- `LEDBITS`, 8: width of the LED output register.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `BefehlAnfrage`  in  1  fetch request, held high until `BefehlBereit`.
- `BefehlAdresse`  in  32  fetch word address.
- `Befehl`  out  WORDSIZE  fetched instruction, valid while `BefehlBereit` is high.
- `BefehlBereit`  out  1  one-cycle fetch completion pulse.
- `DatenLesen`  in  1  load request, held until `DatenFertig`.
- `DatenSchreiben`  in  1  store request, held until `DatenFertig`.
- `DatenAdresse`  in  32  load/store word address.
- `DatenSchreibwert`  in  WORDSIZE  store data.
- `DatenLesewert`  out  WORDSIZE  load result, valid while `DatenFertig` is high.
- `DatenFertig`  out  1  one-cycle load/store completion pulse.
- `RamLesenAn`, `RamSchreibenAn`  out  1  RAM strobes, each high for exactly one cycle per access.
- `RamAdresse`  out  `$clog2(WORDS)`  RAM word address.
- `RamDatenRein`  out  WORDSIZE  RAM write data.
- `RamDatenRaus`  in  WORDSIZE  RAM read data.
- `RamDatenBereit`, `RamDatenGeschrieben`  in  1  RAM completion flags.
- `LEDs`  out  LEDBITS  LED register.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also clears the LED register and forces the state to `IDLE`.
- **States:**
  - `IDLE`: samples requests.
  - `RAM_START`: the RAM strobe is high.
  - `RAM_WARTEN`: waits for the RAM completion flag.
  - `FERTIG`: the completion pulse cycle; no requests are sampled.
  - Transitions: `IDLE`→`FERTIG` directly for I/O accesses; `FERTIG`→`IDLE` always.
- **Arbitration in `IDLE`:**
  - A data request beats a fetch request.
  - `DatenSchreiben` beats `DatenLesen` if both are high.
  - The losing request stays pending, since the requester holds it.
- **Decode:**
  - Address bit 31 = 1 selects I/O (data port only).
  - Otherwise the access goes to RAM, with `RamAdresse` = low `$clog2(WORDS)` address bits; higher bits are ignored, so addresses wrap.
  - A fetch with bit 31 set is treated as a RAM fetch using the low bits.
- **I/O write:** `LEDs` ← `DatenSchreibwert[LEDBITS-1:0]`.
- **I/O read:** returns the LED register zero-extended to WORDSIZE.
- **RAM read:** in `RAM_WARTEN`, when `RamDatenBereit`=1, capture `RamDatenRaus` into `Befehl` or `DatenLesewert`, then go to `FERTIG`.
- **RAM write:** `RamDatenRein` = `DatenSchreibwert` is latched at the strobe. In `RAM_WARTEN`, `RamDatenGeschrieben`=1 completes the access.
- **Response data:** `Befehl` and `DatenLesewert` hold their last value after the pulse.
- **Stray flags:** `RamDatenBereit` or `RamDatenGeschrieben` seen in `IDLE` or `FERTIG` is ignored.
- **Request withdrawal:** a request dropped mid-access is still completed, and its pulse is still issued.

## Timing
Cycle N is the `IDLE` cycle in which the request is sampled.

- **RAM access:**
  - N+1: strobe high.
  - N+2: RAM flag high.
  - N+3: completion pulse with data.
  - Latency is 3 cycles, with one access per 4 cycles back-to-back.
- **I/O access:** the pulse and read data (or the `LEDs` update) appear at N+1.
- **Pulse width:** completion pulses are exactly one cycle wide. Requests still high during `FERTIG` are sampled again only at the following `IDLE`.
- **Reset mid-access:** reset asserted at any time drops the strobes and pulses immediately (asynchronously). No completion pulse is issued for the aborted access.

## Structure
- Shared package `speicher_pkg`:
  - state enum (`IDLE`, `RAM_START`, `RAM_WARTEN`, `FERTIG`);
  - constant `IO_BIT` = 31;
  - request-source enum (`QUELLE_BEFEHL`, `QUELLE_DATEN`).
- One natural sub-module: `led_register`, the I/O register with write enable, async reset and read-back.

## Test plan
- **Reset:** assert `Reset` mid-`RAM_WARTEN` → all outputs 0 and `LEDs` = 0; the later `RamDatenBereit` produces no pulse.
- **Fetch:** `BefehlAdresse`=5 with RAM word 5 = 0x8000_0001 → `RamLesenAn` at N+1, `BefehlBereit` and `Befehl`=0x8000_0001 at N+3.
- **Simultaneous requests:** fetch and store (addr 3, 0xDEAD_BEEF) both high → store served first and the fetch served on the following `IDLE`; RAM word 3 = 0xDEAD_BEEF.
- **I/O store:** addr 0x8000_0000, value 0x0000_01A5 → `LEDs`=0xA5 and `DatenFertig` at N+1, with no RAM strobe; a subsequent I/O load returns 0x0000_00A5.
- **Address wrap:** load from addr 37 with WORDS=32 → `RamAdresse`=5.
